// File: rtl/bictr_cmd_seq.sv
// Command sequencer for an external loadable up/down counter.
// Loads start, runs to target, repeats for extra passes, reports done/aborted.
module bictr_cmd_seq #(
    parameter int WIDTH = 8,
    parameter int LOOPW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic             cmd_dir,
    input  logic [LOOPW-1:0] cmd_loops,
    input  logic             pause,
    input  logic             abort,
    output logic             load,
    output logic             cen,
    output logic             up_dn,
    output logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] count_to,
    input  logic             tercnt,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [LOOPW-1:0] pass_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [LOOPW-1:0] loops_q;

    // Counter steps only in RUN, and stops on the terminal count in the same cycle
    assign cen = (state == RUN) & ~pause & ~tercnt & ~abort;

    // Command FSM with registered handshake, load and status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            loops_q   <= '0;
            load      <= 1'b1;
            up_dn     <= 1'b1;
            data      <= '0;
            count_to  <= '0;
            pass_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        data      <= cmd_start;
                        count_to  <= cmd_target;
                        up_dn     <= cmd_dir;
                        loops_q   <= cmd_loops;
                        pass_cnt  <= '0;
                        load      <= 1'b0;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    load <= 1'b1;
                    if (abort) begin
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        aborted   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        load      <= 1'b1;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        aborted   <= 1'b1;
                        state     <= IDLE;
                    end else if (tercnt) begin
                        if (pass_cnt == loops_q) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            pass_cnt <= pass_cnt + 1'b1;
                            load     <= 1'b0;
                            state    <= LOAD;
                        end
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    load      <= 1'b1;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bictr_cmd_seq.sv
// Bench for bictr_cmd_seq: behavioural counter plus end-of-command scoreboard.
// Directed commands push expected end events; a monitor pops and compares.
module tb_bictr_cmd_seq;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_start;
    logic [7:0] cmd_target;
    logic       cmd_dir;
    logic [3:0] cmd_loops;
    logic       pause;
    logic       abort;
    logic       load;
    logic       cen;
    logic       up_dn;
    logic [7:0] data;
    logic [7:0] count_to;
    logic       tercnt;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [3:0] pass_cnt;

    bictr_cmd_seq #(.WIDTH(8), .LOOPW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_start  (cmd_start),
        .cmd_target (cmd_target),
        .cmd_dir    (cmd_dir),
        .cmd_loops  (cmd_loops),
        .pause      (pause),
        .abort      (abort),
        .load       (load),
        .cen        (cen),
        .up_dn      (up_dn),
        .data       (data),
        .count_to   (count_to),
        .tercnt     (tercnt),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .pass_cnt   (pass_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External counter the sequencer drives
    logic [7:0] cnt = 8'd0;
    always @(posedge clk) begin
        if (!load)
            cnt <= data;
        else if (cen)
            cnt <= up_dn ? cnt + 8'd1 : cnt - 8'd1;
    end
    assign tercnt = (cnt == count_to);

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Cycle index and accept cycle for latency measurement
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cmd_valid && cmd_ready)
            acc <= cyc;
    end

    typedef struct {
        bit         ab;
        int         lat;
        logic [7:0] cnt;
    } exp_t;
    exp_t sbq[$];

    // Monitor: every done/aborted pulse must match the head of the queue
    always @(negedge clk) begin
        exp_t e;
        if (reset && (done || aborted)) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_end: done=%0b aborted=%0b none expected",
                         done, aborted);
            end else begin
                e = sbq.pop_front();
                chk("end_kind", {30'd0, done, aborted},
                    e.ab ? 32'd1 : 32'd2);
                chk("end_latency", cyc - acc, e.lat);
                chk("end_count", {24'd0, cnt}, {24'd0, e.cnt});
            end
        end
    end

    task automatic issue(input logic [7:0] s, input logic [7:0] t,
                         input logic d, input logic [3:0] l,
                         input bit push, input bit ab,
                         input int lat, input logic [7:0] c);
        exp_t e;
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_start  = s;
        cmd_target = t;
        cmd_dir    = d;
        cmd_loops  = l;
        if (push) begin
            e.ab  = ab;
            e.lat = lat;
            e.cnt = c;
            sbq.push_back(e);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(cmd_ready && sbq.size() == 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'd0, n < 300}, 32'd1);
    endtask

    task automatic wait_cnt(input logic [7:0] v);
        int n = 0;
        while (!(cnt == v && busy && load && !done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("cnt_wait_timeout", {31'd0, n < 100}, 32'd1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_load", load, 1);
        chk("rst_cen", cen, 0);
        chk("rst_up_dn", up_dn, 1);
        chk("rst_data", data, 0);
        chk("rst_count_to", count_to, 0);
        chk("rst_pass_cnt", pass_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_start  = 8'd0;
        cmd_target = 8'd0;
        cmd_dir    = 1'b0;
        cmd_loops  = 4'd0;
        pause      = 1'b0;
        abort      = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        reset = 1'b1;
        @(negedge clk);

        // 10 -> 13 up, cycle-by-cycle
        issue(8'd10, 8'd13, 1'b1, 4'd0, 1'b1, 1'b0, 6, 8'd13);
        chk("c1_load", load, 0);
        chk("c1_cen", cen, 0);
        chk("c1_busy", busy, 1);
        chk("c1_cmd_ready", cmd_ready, 0);
        chk("c1_data", data, 10);
        chk("c1_count_to", count_to, 13);
        chk("c1_up_dn", up_dn, 1);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            chk("t1_count", cnt, 8 + k);
            chk("t1_cen", cen, (k < 5) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        chk("c6_done", done, 1);
        @(negedge clk);
        chk("c7_cmd_ready", cmd_ready, 1);
        chk("c7_busy", busy, 0);
        wait_idle();

        // Down through zero: 2,1,0,255,254
        issue(8'd2, 8'd254, 1'b0, 4'd0, 1'b1, 1'b0, 7, 8'd254);
        wait_idle();

        // Up through wrap: 250 -> 3, nine steps
        issue(8'd250, 8'd3, 1'b1, 4'd0, 1'b1, 1'b0, 12, 8'd3);
        wait_idle();

        // Zero-step passes, three of them
        issue(8'd5, 8'd5, 1'b1, 4'd2, 1'b1, 1'b0, 7, 8'd5);
        for (int p = 0; p < 3; p++) begin
            chk("loop_load", load, 0);
            chk("loop_pass_cnt", pass_cnt, p);
            repeat (2) @(negedge clk);
        end
        wait_idle();

        // Pause held for three cycles at count 11
        issue(8'd10, 8'd13, 1'b1, 4'd0, 1'b1, 1'b0, 9, 8'd13);
        wait_cnt(8'd11);
        pause = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("pause_hold", cnt, 11);
        end
        @(negedge clk);
        pause = 1'b0;
        wait_idle();

        // Pause high through LOAD has no effect on a zero-step pass
        pause = 1'b1;
        issue(8'd7, 8'd7, 1'b0, 4'd0, 1'b1, 1'b0, 3, 8'd7);
        pause = 1'b0;
        wait_idle();

        // Abort coinciding with tercnt
        issue(8'd10, 8'd13, 1'b1, 4'd0, 1'b1, 1'b1, 6, 8'd13);
        wait_cnt(8'd13);
        chk("ab_tercnt", tercnt, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_cmd_ready", cmd_ready, 1);
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        chk("ab_load", load, 1);
        wait_idle();

        // Abort while idle is ignored
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort", aborted, 0);

        // Asynchronous reset in the middle of a run
        issue(8'd0, 8'd200, 1'b1, 4'd0, 1'b0, 1'b0, 0, 8'd0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_reset_vals();
        @(negedge clk);
        reset = 1'b1;
        issue(8'd10, 8'd13, 1'b1, 4'd0, 1'b1, 1'b0, 6, 8'd13);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bictr_cmd_seq.md
BICTR_CMD_SEQ -- requirements
Module: bictr_cmd_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter data width.
REQ-002 SHALL have parameter LOOPW, default 4: width of the pass-repeat field.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1: command offered.
REQ-006 SHALL have port cmd_ready, output, 1: command can be accepted.
REQ-007 SHALL have port cmd_start, input, WIDTH: counter load value.
REQ-008 SHALL have port cmd_target, input, WIDTH: terminal count value.
REQ-009 SHALL have port cmd_dir, input, 1: 1 = count up, 0 = count down.
REQ-010 SHALL have port cmd_loops, input, LOOPW: extra passes after the first.
REQ-011 SHALL have port pause, input, 1: freeze counting while high.
REQ-012 SHALL have port abort, input, 1: terminate the current command.
REQ-013 SHALL have port load, output, 1: counter load, active-low.
REQ-014 SHALL have port cen, output, 1: counter enable, active-high.
REQ-015 SHALL have port up_dn, output, 1: counter direction.
REQ-016 SHALL have port data, output, WIDTH: counter load data.
REQ-017 SHALL have port count_to, output, WIDTH: counter terminal value.
REQ-018 SHALL have port tercnt, input, 1: counter flag, high when count equals count_to.
REQ-019 SHALL have port busy, output, 1: command in progress.
REQ-020 SHALL have port done, output, 1: one-cycle pulse on normal completion.
REQ-021 SHALL have port aborted, output, 1: one-cycle pulse on abort.
REQ-022 SHALL have port pass_cnt, output, LOOPW: index of the current pass.

Function
REQ-023 SHALL use four states: IDLE, LOAD, RUN, DONE.
REQ-024 IDLE: cmd_ready=1; when cmd_valid=1, SHALL capture start, target, dir and loops, clear pass_cnt, and go to LOAD.
REQ-025 LOAD: SHALL hold load=0 for exactly one cycle with cen=0 and data/count_to/up_dn driven from the captured values, then go to RUN.
REQ-026 RUN: SHALL drive cen = ~pause & ~tercnt (combinational on tercnt), so the counter never steps past the target.
REQ-027 RUN with tercnt=1 and pass_cnt==loops: SHALL go to DONE.
REQ-028 RUN with tercnt=1 and pass_cnt<loops: SHALL increment pass_cnt and go to LOAD to reload cmd_start.
REQ-029 DONE: SHALL pulse done=1 for one cycle, then go to IDLE.
REQ-030 cmd_ready SHALL be 1 only in IDLE; busy SHALL be 1 in LOAD, RUN and DONE.
REQ-031 Latency: for a pass of N = (target-start) mod 2^WIDTH steps (up) or (start-target) mod 2^WIDTH steps (down), no pause, SHALL run from accept edge to done for 1 LOAD + N+1 RUN cycles.
REQ-032 Wrap-around: SHALL rely on the counter's modulo-2^WIDTH wrap with no special handling.
REQ-033 start==target: SHALL count as a zero-step pass; tercnt is seen in the first RUN cycle.
REQ-034 abort=1 in LOAD or RUN: SHALL go to IDLE next edge, pulse aborted, hold load=1 and cen=0, and not pulse done.
REQ-035 abort and tercnt high in the same cycle: abort SHALL take priority.
REQ-036 abort in IDLE or DONE: SHALL be ignored.
REQ-037 pause SHALL be ignored outside RUN.
REQ-038 data, count_to and up_dn SHALL stay stable from LOAD until the command ends.

Reset
REQ-039 While reset=0, SHALL force state=IDLE, load=1, cen=0, up_dn=1, data=0, count_to=0, pass_cnt=0, busy=0, done=0, aborted=0, and cmd_ready=1.
REQ-040 Reset mid-command SHALL discard the command with no done or aborted pulse.

Verification
REQ-041 start=10, target=13, dir=1, loops=0 accepted at cycle 0 -> load=0 in cycle 1; count 10/11/12/13 in cycles 2-5; cen=0 in cycle 5; done=1 in cycle 6; cmd_ready=1 in cycle 7.
REQ-042 start=2, target=254, dir=0, loops=0 -> count 2,1,0,255,254; done 6 cycles after LOAD; no overshoot to 253.
REQ-043 start=target=5, loops=2 -> three LOAD/RUN pairs of 2 cycles each; pass_cnt 0,1,2; single done pulse.
REQ-044 Run 10->13 with pause=1 for 3 cycles while count=11 -> count holds at 11; done delayed exactly 3 cycles.
REQ-045 abort=1 in the same cycle tercnt=1 -> aborted pulse, no done, IDLE next cycle.
REQ-046 reset=0 mid-RUN -> all REQ-039 values immediately, without waiting for clk; new command accepted normally after release.
